// File: rtl/occ_table_writer.sv
// FM-index Occ table builder: streams BWT symbols and writes one packed
// cumulative-count word {t,g,c,a} per position into the Occ memory.
module occ_table_writer #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [1:0]          s_sym,
  input  logic                s_end,
  input  logic                s_last,
  output logic                wr_en,
  input  logic                wr_ready,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [4*CNT_W-1:0]  wr_data,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [ADDR_W-1:0]   entries
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] IDX_MAX = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  state_t                   state_q, state_d;
  logic [3:0][CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]        idx_q, idx_d;
  logic [ADDR_W-1:0]        entries_q, entries_d;
  logic [ADDR_W-1:0]        wr_addr_q, wr_addr_d;
  logic [4*CNT_W-1:0]       wr_data_q, wr_data_d;
  logic                     wr_en_q, wr_en_d;
  logic                     error_q, error_d;
  logic                     wr_hs, acc;

  assign s_ready = (state_q == S_RUN) && (!wr_en_q || wr_ready);
  assign acc     = s_valid && s_ready;
  assign wr_hs   = wr_en_q && wr_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    entries_d = entries_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_en_d   = wr_en_q;
    error_d   = error_q;

    if (wr_hs) begin
      wr_en_d   = 1'b0;
      entries_d = wr_addr_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RUN;
          cnt_d     = '0;
          idx_d     = '0;
          entries_d = '0;
          error_d   = 1'b0;
        end
      end
      S_RUN: begin
        if (acc) begin
          // The all-ones address means "-1" to the reader, so a symbol
          // landing there is an overflow rather than a write.
          if (idx_q == IDX_MAX) begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            for (int i = 0; i < 4; i++) begin
              if (!s_end && s_sym == 2'(i)) begin
                if (cnt_q[i] == CNT_MAX) error_d = 1'b1;
                else                     cnt_d[i] = cnt_q[i] + 1'b1;
              end
            end
            wr_en_d   = 1'b1;
            wr_addr_d = idx_q;
            wr_data_d = cnt_d;
            idx_d     = idx_q + 1'b1;
            if (s_last) state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: if (wr_hs) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      entries_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      entries_q <= entries_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      error_q   <= error_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign entries = entries_q;
  assign error   = error_q;
  assign busy    = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done    = (state_q == S_DONE);

endmodule
